// File: rtl/mult4_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult4_pkg;

  // Default operand width; also the adder width and the iteration count.
  localparam int N_DEFAULT = 4;

  // Controller state encoding. The unused code 2'd3 is steered back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter. The extra bit leaves headroom above N-1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mult4_seq_add_rc.sv
// Parameterised N-bit ripple-carry adder built from a chain of full adders.
module add_rc #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    // One full adder: sum bit and carry into the next stage.
    always_comb begin
      sum[i]       = x[i] ^ y[i] ^ w_carry[i];
      w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = w_carry[N];

endmodule

// File: rtl/mult4_seq.sv
// Shift-and-add multiplier controller: one shared N-bit adder, N iterations,
// start/busy/done handshake, registered 2N-bit product.
module mult4_seq
  import mult4_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           CLOCK_50,
  input  logic           Reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_width(N);

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_areg;
  logic [2*N-1:0]  r_p;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [2*N-1:0]  r_product;

  logic [N-1:0]    w_y;
  logic [N-1:0]    w_sum;
  logic            w_cout;
  logic [2*N-1:0]  w_p_next;
  logic            w_last;

  // Add the multiplicand only when the current multiplier bit is set; the
  // adder still runs (adding zero) on every RUN cycle.
  assign w_y      = r_p[0] ? r_areg : '0;
  assign w_p_next = {w_cout, w_sum, r_p[N-1:1]};
  assign w_last   = (r_cnt == CW'(N - 1));

  add_rc #(.N(N)) u_add (
    .x    (r_p[2*N-1:N]),
    .y    (w_y),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // State register; reset is synchronous and overrides any operation.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment first means every path drives w_state_next,
  // so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and output registers: capture, iterate, publish the product.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_areg    <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_areg <= a;
            r_p    <= {{N{1'b0}}, b};
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= w_p_next;
            r_done    <= 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: doc/mult4_seq.md
# mult4_seq

Sequential shift-and-add multiplier controller that schedules a single shared N-bit ripple-carry adder over N iterations to form a 2N-bit unsigned product. It runs the adder datapath (full-adder chain with carry-in/carry-out) as a multi-cycle arithmetic unit behind a start/busy/done handshake. It sits between switch/register inputs and LED/display outputs.

## Interface
- N, default 4: operand width; also the adder width and the iteration count.
- CLOCK_50  input  1  sole clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  multiplicand, captured when start is accepted.
- b  input  N  multiplier, captured when start is accepted.
- busy  output  1  high from acceptance until return to IDLE.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2N  registered result; held until the next done.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: N iterations.
  - DONE: one cycle.
- IDLE, start=1:
  - areg <= a; P <= {N'b0, b}; cnt <= 0; busy <= 1; go to RUN.
  - In IDLE with start=0, nothing changes.
- RUN iteration, one per cycle:
  - Adder inputs: x = P[2N-1:N], y = P[0] ? areg : 0, cin = 0.
  - P <= {cout, sum, P[N-1:1]}; cnt <= cnt+1.
  - The adder is used every RUN cycle, including when y = 0.
- After the Nth RUN edge: product <= final P; done <= 1; go to DONE.
- DONE: done <= 0; busy <= 0; go to IDLE.
- start is ignored in RUN and DONE. a and b may change freely after acceptance.
- Arithmetic:
  - Unsigned only. The result always fits in 2N bits, so there is no overflow flag.
  - cout of each iteration becomes the new MSB of P and is never dropped.
- Reset = 1 at any edge:
  - state <= IDLE; busy, done <= 0; product <= 0; P, areg, cnt <= 0.
  - Reset wins over start and over any in-flight operation. An aborted operation never asserts done.

## Timing
- Reset values: busy = 0, done = 0, product = 0.
- Start sampled at edge E0:
  - busy is high from after E0.
  - RUN iterations occur at edges E1..EN.
  - done is high for exactly one cycle, after EN and before EN+1.
  - busy falls at EN+1.
- Latency is N+1 edges from start sample to done high; N=4 gives done after E4.
- product updates only at EN and is stable while done is high and afterwards.
- Back-to-back: with start held high, the next acceptance is at EN+2. Peak throughput is one product per N+2 cycles.
- busy and done are registered; no output is a combinational function of an input.

## Structure
- Shared package (mult4_pkg):
  - State encoding localparams: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2; 2'd3 returns to IDLE.
  - Default N.
  - Counter width function ($clog2(N)+1).
- One sub-module, add_rc: parameterised N-bit ripple-carry adder with ports x, y, cin, sum, cout.
  - Built from a generate chain of single-bit full adders.
  - Instantiated exactly once; the controller is its only user.
- The controller holds only the FSM, cnt, areg, P and the output registers.

## Test plan
- Reset, then a=4'hF, b=4'hF, one-cycle start -> done after E4, product = 8'hE1; busy high for exactly 5 cycles.
- a=4'h0, b=4'hB -> product = 8'h00; a=4'h9, b=4'h1 -> product = 8'h09; a=4'h1, b=4'h9 -> product = 8'h09.
- After starting a=3, b=5, pulse start with a=7, b=7 at E2 -> ignored; done after E4 with product = 8'h0F; no second done.
- Start a=4'hC, b=4'hD, assert Reset at E2 -> busy = 0, done never pulses, product = 0; a fresh start then gives 8'h9C.
- start held high continuously with a=2, b=3 -> done pulses every 6 cycles, product = 8'h06 each time.
- Exhaustive: all 256 (a, b) pairs checked against a*b, one per operation.
